// File: rtl/bus_wrr_scheduler.sv
// Weighted round-robin bus scheduler: arbitrates between drvrs source FIFOs, pops the winner's head
// and pushes it to its destination port(s). Optional build macro: BUS_WRR_SELF_DELIVERY_EN.
module bus_wrr_scheduler #(
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF,
  parameter int unsigned weight_w  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [drvrs-1:0]              pndng,
  input  logic [drvrs*pckg_sz-1:0]      D_pop,
  input  logic [drvrs*weight_w-1:0]     weights,
  output logic [drvrs-1:0]              pop,
  output logic [drvrs-1:0]              push,
  output logic [pckg_sz-1:0]            D_push,
  output logic [$clog2(drvrs)-1:0]      grant_id,
  output logic                          busy,
  output logic [15:0]                   drop_cnt
);

  localparam int unsigned IdxW = $clog2(drvrs);

  typedef enum logic [1:0] {StIdle, StArb, StPop, StPush} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [pckg_sz-1:0]    data_q, data_d;
  logic [pckg_sz-1:0]    dpush_q, dpush_d;
  logic [15:0]           drop_q, drop_d;
  logic                  init_q;
  logic [weight_w-1:0]   credit_q [drvrs];
  logic [weight_w-1:0]   credit_d [drvrs];
  logic [weight_w-1:0]   reload_val [drvrs];

  logic [drvrs-1:0]      elig;
  logic                  found;
  logic [IdxW-1:0]       winner;
  int                    idx;
  logic [7:0]            dest;
  logic                  dest_valid;

  // Zero weight behaves as weight 1 so every device keeps at least one slot per round.
  always_comb begin
    for (int i = 0; i < int'(drvrs); i++) begin
      reload_val[i] = weights[i*weight_w +: weight_w];
      if (reload_val[i] == '0) begin
        reload_val[i] = weight_w'(1);
      end
    end
  end

  assign dest       = data_q[pckg_sz-1 -: 8];
  assign dest_valid = (32'(dest) < drvrs);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    dpush_d  = dpush_q;
    drop_d   = drop_q;
    credit_d = credit_q;
    pop      = '0;
    push     = '0;
    elig     = '0;
    found    = 1'b0;
    winner   = '0;
    idx      = 0;

    // First edge after reset release samples the weights into the credit counters.
    if (init_q) begin
      credit_d = reload_val;
    end

    unique case (state_q)
      StIdle: begin
        if (|pndng) begin
          state_d = StArb;
        end
      end

      StArb: begin
        if (pndng == '0) begin
          state_d = StIdle;
        end else begin
          for (int i = 0; i < int'(drvrs); i++) begin
            elig[i] = pndng[i] && (credit_q[i] != '0);
          end
          if (elig == '0) begin
            credit_d = reload_val;
            elig     = pndng;
          end
          for (int k = 1; k <= int'(drvrs); k++) begin
            idx = (int'(rr_ptr_q) + k) % int'(drvrs);
            if (!found && elig[idx]) begin
              found  = 1'b1;
              winner = IdxW'(idx);
            end
          end
          grant_d = winner;
          state_d = StPop;
        end
      end

      StPop: begin
        if (pndng[grant_q]) begin
          pop[grant_q] = 1'b1;
          data_d       = D_pop[int'(grant_q)*pckg_sz +: pckg_sz];
          state_d      = StPush;
        end else begin
          state_d = StIdle;
        end
      end

      StPush: begin
        dpush_d = data_q;
        if (dest == broadcast) begin
          push          = '1;
          push[grant_q] = 1'b0;
        end else if (dest_valid && (dest != 8'(grant_q))) begin
          push[dest[IdxW-1:0]] = 1'b1;
        end
`ifdef BUS_WRR_SELF_DELIVERY_EN
        else if (dest_valid) begin
          push[grant_q] = 1'b1;
        end
`endif
        else begin
          if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
        if (credit_q[grant_q] != '0) begin
          credit_d[grant_q] = credit_q[grant_q] - weight_w'(1);
        end
        rr_ptr_d = grant_q;
        state_d  = (|pndng) ? StArb : StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= IdxW'(drvrs - 1);
      data_q   <= '0;
      dpush_q  <= '0;
      drop_q   <= '0;
      init_q   <= 1'b1;
      for (int i = 0; i < int'(drvrs); i++) begin
        credit_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      dpush_q  <= dpush_d;
      drop_q   <= drop_d;
      init_q   <= 1'b0;
      credit_q <= credit_d;
    end
  end

  // The captured packet is visible during PUSH and held afterwards until the next PUSH.
  assign D_push   = (state_q == StPush) ? data_q : dpush_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);
  assign drop_cnt = drop_q;

endmodule
